lut_writer: RTL and testbench

LUT_WRITER -- requirements
Module: lut_writer

---
 rtl/lut_writer_pkg.sv | 19 +
 rtl/lut_writer.sv | 158 +++++++++++++++
 tb/tb_lut_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lut_writer_pkg.sv
// Shared definitions for the key/data LUT writer: FSM encoding and width helpers.
package lut_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

    function automatic int idx_width(input int nr_key);
        return (nr_key > 1) ? $clog2(nr_key) : 1;
    endfunction

endpackage

// File: rtl/lut_writer.sv
// Builds a packed key/data table one command at a time, scanning for duplicate keys.
// Define LUT_WRITER_OVERWRITE_EN to let a duplicate key update its data instead of being rejected.
module lut_writer
    import lut_writer_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_clr,
    input  logic [KEY_LEN-1:0]                   cmd_key,
    input  logic [DATA_LEN-1:0]                  cmd_data,
    output logic                                 done,
    output logic                                 err,
    output logic [$clog2(NR_KEY+1)-1:0]          count,
    output logic                                 full,
    output logic [NR_KEY-1:0]                    valid_mask,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);
    localparam int IDX_W    = idx_width(NR_KEY);
    localparam int CNT_W    = $clog2(NR_KEY + 1);

    typedef logic [PAIR_LEN-1:0] entry_t;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hit_q, hit_d;
    logic [KEY_LEN-1:0]  key_q, key_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NR_KEY-1:0]   mask_q, mask_d;
    entry_t              entry_q [NR_KEY];
    entry_t              entry_d [NR_KEY];

    logic                full_w;
    logic                key_match;
    logic                last_idx;
    logic [IDX_W-1:0]    tail_idx;

    assign full_w    = (count_q == CNT_W'(NR_KEY));
    assign key_match = (entry_q[idx_q][PAIR_LEN-1 -: KEY_LEN] == key_q);
    assign last_idx  = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
    assign tail_idx  = IDX_W'(count_q);

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        key_d   = key_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        mask_d  = mask_q;
        entry_d = entry_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_clr) begin
                        state_d = CLEAR;
                    end else begin
                        key_d   = cmd_key;
                        data_d  = cmd_data;
                        idx_d   = '0;
                        hit_d   = 1'b0;
                        state_d = (count_q == '0) ? COMMIT : SCAN;
                    end
                end
            end
            SCAN: begin
                if (key_match) begin
                    hit_d   = 1'b1;
                    state_d = COMMIT;
                end else if (last_idx) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            COMMIT: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (hit_q) begin
`ifdef LUT_WRITER_OVERWRITE_EN
                    entry_d[idx_q][DATA_LEN-1:0] = data_q;
`else
                    err_d = 1'b1;
`endif
                end else if (full_w) begin
                    err_d = 1'b1;
                end else begin
                    entry_d[tail_idx] = {key_q, data_q};
                    mask_d[tail_idx]  = 1'b1;
                    count_d           = count_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                done_d  = 1'b1;
                state_d = IDLE;
                count_d = '0;
                mask_d  = '0;
                for (int n = 0; n < NR_KEY; n++) entry_d[n] = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the table storage is reset too, because unoccupied entries must read as zero from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            mask_q  <= '0;
            for (int n = 0; n < NR_KEY; n++) entry_q[n] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            key_q   <= key_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        lut = '0;
        for (int n = 0; n < NR_KEY; n++) lut[PAIR_LEN*n +: PAIR_LEN] = entry_q[n];
    end

    // Ready is gated by rst_n so it stays low for the whole reset pulse.
    assign cmd_ready  = (state_q == IDLE) && rst_n;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;
    assign full       = full_w;
    assign valid_mask = mask_q;

endmodule

// File: tb/tb_lut_writer.sv
// Self-checking bench for lut_writer (NR_KEY=4, KEY_LEN=4, DATA_LEN=8), valid in both
// the default build and with LUT_WRITER_OVERWRITE_EN defined.
module tb_lut_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clr;
    logic [3:0]  cmd_key;
    logic [7:0]  cmd_data;
    logic        done;
    logic        err;
    logic [2:0]  count;
    logic        full;
    logic [3:0]  valid_mask;
    logic [47:0] lut;

    int n_checks = 0;
    int n_fail   = 0;

    lut_writer #(
        .NR_KEY   (4),
        .KEY_LEN  (4),
        .DATA_LEN (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_clr    (cmd_clr),
        .cmd_key    (cmd_key),
        .cmd_data   (cmd_data),
        .done       (done),
        .err        (err),
        .count      (count),
        .full       (full),
        .valid_mask (valid_mask),
        .lut        (lut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [3:0]  key;
        logic [7:0]  data;
        int          lat;
        logic        err;
        logic [2:0]  cnt;
        logic [3:0]  mask;
        logic [47:0] lut;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Call at the negedge following E0; returns the number of edges after E0 until done shows.
    task automatic wait_done(output int lat, output logic err_seen);
        bit found;
        found    = 1'b0;
        lat      = 0;
        err_seen = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                found    = 1'b1;
                lat      = c;
                err_seen = err;
            end else begin
                check("err_without_done", {63'b0, err}, 64'd0);
            end
        end
        if (!found) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_cmd(input logic clr, input logic [3:0] key, input logic [7:0] data,
                          output int lat, output logic err_seen);
        @(negedge clk);
        check("ready_before_accept", {63'b0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        cmd_key   = key;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(lat, err_seen);
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        int   lat;
        logic e;

        //           clr   key   data    lat err   cnt   mask  lut (entry3_entry2_entry1_entry0)
        vecs[0]  = '{1'b0, 4'h3, 8'hA5, 1, 1'b0, 3'd1, 4'h1, 48'h000_000_000_3A5};
        vecs[1]  = '{1'b1, 4'h0, 8'h00, 1, 1'b0, 3'd0, 4'h0, 48'h000_000_000_000};
        vecs[2]  = '{1'b0, 4'h1, 8'h11, 1, 1'b0, 3'd1, 4'h1, 48'h000_000_000_111};
        vecs[3]  = '{1'b0, 4'h2, 8'h22, 2, 1'b0, 3'd2, 4'h3, 48'h000_000_222_111};
        vecs[4]  = '{1'b0, 4'h5, 8'h55, 3, 1'b0, 3'd3, 4'h7, 48'h000_555_222_111};
`ifdef LUT_WRITER_OVERWRITE_EN
        vecs[5]  = '{1'b0, 4'h2, 8'h77, 3, 1'b0, 3'd3, 4'h7, 48'h000_555_277_111};
        vecs[6]  = '{1'b0, 4'h8, 8'h88, 4, 1'b0, 3'd4, 4'hF, 48'h888_555_277_111};
        vecs[7]  = '{1'b0, 4'h9, 8'h99, 5, 1'b1, 3'd4, 4'hF, 48'h888_555_277_111};
        vecs[8]  = '{1'b0, 4'h1, 8'hEE, 2, 1'b0, 3'd4, 4'hF, 48'h888_555_277_1EE};
`else
        vecs[5]  = '{1'b0, 4'h2, 8'h77, 3, 1'b1, 3'd3, 4'h7, 48'h000_555_222_111};
        vecs[6]  = '{1'b0, 4'h8, 8'h88, 4, 1'b0, 3'd4, 4'hF, 48'h888_555_222_111};
        vecs[7]  = '{1'b0, 4'h9, 8'h99, 5, 1'b1, 3'd4, 4'hF, 48'h888_555_222_111};
        vecs[8]  = '{1'b0, 4'h1, 8'hEE, 2, 1'b1, 3'd4, 4'hF, 48'h888_555_222_111};
`endif
        vecs[9]  = '{1'b1, 4'h0, 8'h00, 1, 1'b0, 3'd0, 4'h0, 48'h000_000_000_000};
        vecs[10] = '{1'b0, 4'h4, 8'h44, 1, 1'b0, 3'd1, 4'h1, 48'h000_000_000_444};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_clr   = 1'b0;
        cmd_key   = '0;
        cmd_data  = '0;

        // Reset state
        #12;
        check("rst_ready", {63'b0, cmd_ready}, 64'd0);
        check("rst_done",  {63'b0, done},      64'd0);
        check("rst_err",   {63'b0, err},       64'd0);
        check("rst_count", {61'b0, count},     64'd0);
        check("rst_full",  {63'b0, full},      64'd0);
        check("rst_mask",  {60'b0, valid_mask}, 64'd0);
        check("rst_lut",   {16'b0, lut},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", {63'b0, cmd_ready}, 64'd1);

        // Table-driven command sequence
        for (int v = 0; v < 11; v++) begin
            do_cmd(vecs[v].clr, vecs[v].key, vecs[v].data, lat, e);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
            check($sformatf("v%0d_err", v),   {63'b0, e},          {63'b0, vecs[v].err});
            check($sformatf("v%0d_count", v), {61'b0, count},      {61'b0, vecs[v].cnt});
            check($sformatf("v%0d_full", v),  {63'b0, full},       {63'b0, (vecs[v].cnt == 3'd4)});
            check($sformatf("v%0d_mask", v),  {60'b0, valid_mask}, {60'b0, vecs[v].mask});
            check($sformatf("v%0d_lut", v),   {16'b0, lut},        {16'b0, vecs[v].lut});
        end

        // Back-to-back: second command accepted in the cycle done is high; valid held throughout
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_clr   = 1'b0;
        cmd_key   = 4'h6;
        cmd_data  = 8'h66;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat, e);
        check("b2b_first_latency", 64'(lat), 64'd2);
        check("b2b_ready_with_done", {63'b0, cmd_ready}, 64'd1);
        cmd_key  = 4'h7;
        cmd_data = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_accepted", {63'b0, cmd_ready}, 64'd0);
        wait_done(lat, e);
        check("b2b_second_latency", 64'(lat), 64'd3);
        check("b2b_err",   {63'b0, e},      64'd0);
        check("b2b_count", {61'b0, count},  64'd3);
        check("b2b_lut",   {16'b0, lut},    {16'b0, 48'h000_777_666_444});

        // Reset asserted asynchronously while scanning
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_key   = 4'hF;
        cmd_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("scan_busy", {63'b0, cmd_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_lut",   {16'b0, lut},        64'd0);
        check("mid_rst_count", {61'b0, count},      64'd0);
        check("mid_rst_mask",  {60'b0, valid_mask}, 64'd0);
        check("mid_rst_full",  {63'b0, full},       64'd0);
        check("mid_rst_done",  {63'b0, done},       64'd0);
        check("mid_rst_err",   {63'b0, err},        64'd0);
        check("mid_rst_ready", {63'b0, cmd_ready},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("mid_rst_ready_after", {63'b0, cmd_ready}, 64'd1);
            check("mid_rst_no_done", {63'b0, done}, 64'd0);
        end

        // Table is empty again: a write lands in entry 0 with minimum latency
        do_cmd(1'b0, 4'hA, 8'h5A, lat, e);
        check("post_rst_latency", 64'(lat), 64'd1);
        check("post_rst_count", {61'b0, count}, 64'd1);
        check("post_rst_lut",   {16'b0, lut},   {16'b0, 48'h000_000_000_A5A});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
